mux_sel_pipe: RTL and testbench

MUX_SEL_PIPE -- requirements
Module: mux_sel_pipe

---
 rtl/mux_sel_pipe_if.sv | 21 ++
 rtl/mux_sel_pipe.sv | 93 +++++++++
 tb/tb_mux_sel_pipe.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_pipe_if.sv
// Request/response bundle for the 32-lane selector pipe.
// master drives lanes and select, slave returns the picked lane.
interface mux_sel_pipe_if #(
  parameter int WIDTH = 1
);
  logic [32*WIDTH-1:0] in;
  logic [4:0]          sel;
  logic                in_valid;
  logic [WIDTH-1:0]    out;
  logic                out_valid;

  modport master (
    output in, sel, in_valid,
    input  out, out_valid
  );

  modport slave (
    input  in, sel, in_valid,
    output out, out_valid
  );
endinterface

// File: rtl/mux_sel_pipe.sv
// 32:1 lane selector, two 16:1 halves then a 2:1 merge.
// Two register stages, one request per cycle, no stall.
module mux_sel_pipe_sel16 #(
  parameter int WIDTH = 1
) (
  input  logic [16*WIDTH-1:0] d,
  input  logic [3:0]          s,
  output logic [WIDTH-1:0]    y
);
  // Pass lane s through untouched.
  always_comb begin
    y = d[s*WIDTH +: WIDTH];
  end
endmodule

module mux_sel_pipe_sel2 #(
  parameter int WIDTH = 1
) (
  input  logic [2*WIDTH-1:0] d,
  input  logic               s,
  output logic [WIDTH-1:0]   y
);
  // Lane 1 when s is high, else lane 0.
  always_comb begin
    y = s ? d[WIDTH +: WIDTH] : d[0 +: WIDTH];
  end
endmodule

module mux_sel_pipe #(
  parameter int WIDTH = 1
) (
  input logic            clk,
  input logic            reset,
  mux_sel_pipe_if.slave  bus
);
  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             hsel;
    logic             vld;
  } s1_t;

  logic [WIDTH-1:0] lo_y;
  logic [WIDTH-1:0] hi_y;
  logic [WIDTH-1:0] mg_y;
  s1_t              s1_q;
  logic [WIDTH-1:0] out_q;
  logic             vld_q;

  mux_sel_pipe_sel16 #(.WIDTH(WIDTH)) u_lo (
    .d (bus.in[16*WIDTH-1:0]),
    .s (bus.sel[3:0]),
    .y (lo_y)
  );

  mux_sel_pipe_sel16 #(.WIDTH(WIDTH)) u_hi (
    .d (bus.in[32*WIDTH-1:16*WIDTH]),
    .s (bus.sel[3:0]),
    .y (hi_y)
  );

  mux_sel_pipe_sel2 #(.WIDTH(WIDTH)) u_mg (
    .d ({s1_q.hi, s1_q.lo}),
    .s (s1_q.hsel),
    .y (mg_y)
  );

  // Stage 1: both half results, the half pick and the valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= '0;
    end else begin
      s1_q.lo   <= lo_y;
      s1_q.hi   <= hi_y;
      s1_q.hsel <= bus.sel[4];
      s1_q.vld  <= bus.in_valid;
    end
  end

  // Stage 2: merged lane and its valid, updated every cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= mg_y;
      vld_q <= s1_q.vld;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: one WIDTH=1 and one WIDTH=8 instance,
// expectations keyed by the cycle they are due, checked on negedge.
module tb_mux_sel_pipe;
  typedef struct {
    logic       v;
    logic [7:0] d;
    string      tag;
  } ent_t;

  logic clk;
  logic rst1;
  logic rst8;
  int   cyc;
  int   n_chk;
  int   n_pass;

  ent_t exp1[int];
  ent_t exp8[int];

  mux_sel_pipe_if #(.WIDTH(1)) b1 ();
  mux_sel_pipe_if #(.WIDTH(8)) b8 ();

  mux_sel_pipe #(.WIDTH(1)) u1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (b1.slave)
  );

  mux_sel_pipe #(.WIDTH(8)) u8 (
    .clk   (clk),
    .reset (rst8),
    .bus   (b8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Monitor: compare whatever is due after the latest edge.
  always @(negedge clk) begin
    ent_t e;
    if (exp1.exists(cyc)) begin
      e = exp1[cyc];
      exp1.delete(cyc);
      n_chk = n_chk + 1;
      if (b1.out !== e.d[0] || b1.out_valid !== e.v)
        $display("FAIL w1 %s cyc%0d: out=%b vld=%b want out=%b vld=%b",
                 e.tag, cyc, b1.out, b1.out_valid, e.d[0], e.v);
      else
        n_pass = n_pass + 1;
    end
    if (exp8.exists(cyc)) begin
      e = exp8[cyc];
      exp8.delete(cyc);
      n_chk = n_chk + 1;
      if (b8.out !== e.d || b8.out_valid !== e.v)
        $display("FAIL w8 %s cyc%0d: out=%0d vld=%b want out=%0d vld=%b",
                 e.tag, cyc, b8.out, b8.out_valid, e.d, e.v);
      else
        n_pass = n_pass + 1;
    end
  end

  // One request per call; expected result pushed for two edges later.
  task automatic drive(input int d, input logic [255:0] iv,
                       input logic [4:0] s, input logic v,
                       input logic r, input logic [7:0] x,
                       input string tag);
    ent_t e;
    int   c;
    @(posedge clk);
    #1;
    c = cyc;
    e.tag = tag;
    if (d == 1) begin
      b1.in = iv[31:0];
      b1.sel = s;
      b1.in_valid = v;
      rst1 = r;
    end else begin
      b8.in = iv;
      b8.sel = s;
      b8.in_valid = v;
      rst8 = r;
    end
    if (!r) begin
      e.v = 1'b0;
      e.d = 8'd0;
      if (d == 1) begin
        exp1[c+1] = e;
        exp1[c+2] = e;
      end else begin
        exp8[c+1] = e;
        exp8[c+2] = e;
      end
    end else begin
      e.v = v;
      e.d = x;
      if (d == 1) exp1[c+2] = e;
      else exp8[c+2] = e;
    end
  endtask

  initial begin
    logic [255:0] iv;
    logic [255:0] ones;
    int lanes[4];
    n_chk = 0;
    n_pass = 0;
    ones = '1;
    rst1 = 1'b0;
    rst8 = 1'b0;
    b1.in = '1;
    b1.sel = 5'd0;
    b1.in_valid = 1'b1;
    b8.in = '1;
    b8.sel = 5'd0;
    b8.in_valid = 1'b1;

    drive(8, ones, 5'd3, 1'b1, 1'b0, 8'd0, "rst8_a");
    drive(8, ones, 5'd3, 1'b1, 1'b0, 8'd0, "rst8_b");
    drive(1, ones, 5'd20, 1'b1, 1'b0, 8'd0, "rst_a");
    drive(1, ones, 5'd20, 1'b1, 1'b0, 8'd0, "rst_b");

    iv = '0;
    drive(1, iv, 5'd16, 1'b1, 1'b1, 8'd0, "s16_zero");
    iv[16] = 1'b1;
    drive(1, iv, 5'd16, 1'b1, 1'b1, 8'd1, "s16_one");

    lanes = '{24, 28, 30, 31};
    iv = '0;
    foreach (lanes[i]) begin
      drive(1, iv, 5'(lanes[i]), 1'b1, 1'b1, 8'd0, "up_clr");
      iv[lanes[i]] = 1'b1;
      drive(1, iv, 5'(lanes[i]), 1'b1, 1'b1, 8'd1, "up_set");
    end

    iv = '0;
    iv[31] = 1'b1;
    drive(1, iv, 5'd15, 1'b1, 1'b1, 8'd0, "hb_15_0");
    iv[15] = 1'b1;
    drive(1, iv, 5'd15, 1'b1, 1'b1, 8'd1, "hb_15_1");
    drive(1, iv, 5'd31, 1'b1, 1'b1, 8'd1, "hb_31");

    iv = '0;
    iv[5] = 1'b1;
    drive(1, iv, 5'd5, 1'b0, 1'b1, 8'd1, "novld");
    iv = '0;
    iv[31:0] = ~32'h0000_0080;
    drive(1, iv, 5'd7, 1'b1, 1'b1, 8'd0, "indep0");
    iv = '0;
    iv[7] = 1'b1;
    drive(1, iv, 5'd7, 1'b1, 1'b1, 8'd1, "indep1");

    iv = '0;
    iv[3] = 1'b1;
    drive(1, iv, 5'd3, 1'b1, 1'b1, 8'd1, "flight");
    drive(1, iv, 5'd3, 1'b1, 1'b0, 8'd0, "mid_rst");
    drive(1, iv, 5'd3, 1'b1, 1'b1, 8'd1, "post_rst");

    iv = '0;
    for (int k = 0; k < 32; k++) iv[k*8 +: 8] = 8'(k + 1);
    for (int k = 0; k < 32; k++)
      drive(8, iv, 5'(k), 1'b1, 1'b1, 8'(k + 1), "b2b");
    drive(8, iv, 5'd5, 1'b0, 1'b1, 8'd6, "gap");
    drive(8, iv, 5'd9, 1'b1, 1'b1, 8'd10, "after_gap");
    drive(8, iv, 5'd17, 1'b1, 1'b0, 8'd0, "rst8_mid");
    drive(8, iv, 5'd20, 1'b1, 1'b1, 8'd21, "rst8_post");

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    n_chk = n_chk + 1;
    if (exp1.num() + exp8.num() != 0)
      $display("FAIL drain: pending=%0d want 0", exp1.num() + exp8.num());
    else
      n_pass = n_pass + 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
